// File: rtl/gray_pkg.sv
// Shared types, defaults and the Gray->binary helper for the Gray stream decoder.
package gray_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ERR_LIMIT = 3;
  localparam int DEF_CNT_W     = 16;
  localparam int MAX_W         = 64;

  typedef enum logic {ACQ, TRACK} state_t;

  // Zero-extended input makes the top-down prefix XOR correct for any WIDTH <= MAX_W.
  function automatic logic [MAX_W-1:0] gray_to_bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_stream_decoder_if.sv
// Stream bus for the Gray decoder: Gray codes in, decoded words out.
interface gray_stream_decoder_if #(parameter int WIDTH = gray_pkg::DEF_WIDTH);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_gray;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_bin;
   logic             out_dir;
   logic             out_first;
   logic             out_step_err;

   modport master (
      output in_valid, in_gray, out_ready,
      input  in_ready, out_valid, out_bin, out_dir, out_first, out_step_err
   );

   modport slave (
      input  in_valid, in_gray, out_ready,
      output in_ready, out_valid, out_bin, out_dir, out_first, out_step_err
   );
endinterface

// File: rtl/gray_step_checker.sv
// Combinational decode of the current code and classification of the step from the previous code.
module gray_step_checker
   import gray_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] cur_gray,
   input  logic [WIDTH-1:0] prev_gray,
   output logic [WIDTH-1:0] cur_bin,
   output logic             legal,
   output logic             repeat_code,
   output logic             dir
);
   logic [MAX_W-1:0] cur_full, prev_full;
   logic [WIDTH-1:0] prev_bin, delta, diff;
   int unsigned      ones;

   assign cur_full  = gray_to_bin(MAX_W'(cur_gray));
   assign prev_full = gray_to_bin(MAX_W'(prev_gray));
   assign cur_bin   = cur_full[WIDTH-1:0];
   assign prev_bin  = prev_full[WIDTH-1:0];

   assign diff        = cur_gray ^ prev_gray;
   assign ones        = $countones(diff);
   assign legal       = (ones == 1);
   assign repeat_code = (ones == 0);

   // Modular subtraction makes the FF->00 wrap an up-step naturally.
   assign delta = cur_bin - prev_bin;
   assign dir   = legal && (delta == WIDTH'(1));
endmodule

// File: rtl/gray_stream_decoder.sv
// Gray stream decoder: FSM, 1-cycle registered output stage, step/lock/error tracking.
// Build option GRAY_DEC_REPEAT_OK_EN: a repeated code while tracking is a legal hold.
module gray_stream_decoder
   import gray_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ERR_LIMIT = DEF_ERR_LIMIT,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   gray_stream_decoder_if.slave     bus,
   output logic                     locked,
   output logic [CNT_W-1:0]         err_cnt
);
   localparam int CONS_W = $clog2(ERR_LIMIT + 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] prev_gray;
   logic [CONS_W-1:0] cons, cons_nxt;
   logic [CNT_W-1:0] err_nxt;
   logic             first_nxt, serr_nxt, dir_nxt;
   logic             accept;

   logic [WIDTH-1:0] cur_bin;
   logic             legal, repeat_code, step_dir, hold_ok;

   gray_step_checker #(.WIDTH(WIDTH)) u_chk (
      .cur_gray    (bus.in_gray),
      .prev_gray   (prev_gray),
      .cur_bin     (cur_bin),
      .legal       (legal),
      .repeat_code (repeat_code),
      .dir         (step_dir)
   );

`ifdef GRAY_DEC_REPEAT_OK_EN
   assign hold_ok = repeat_code;
`else
   assign hold_ok = repeat_code & 1'b0;
`endif

   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign locked       = (state == TRACK);

   always_comb begin
      state_nxt = state;
      cons_nxt  = cons;
      err_nxt   = err_cnt;
      first_nxt = 1'b0;
      serr_nxt  = 1'b0;
      dir_nxt   = 1'b0;
      case (state)
         ACQ: begin
            first_nxt = 1'b1;
            state_nxt = TRACK;
            cons_nxt  = '0;
         end
         TRACK: begin
            if (legal) begin
               dir_nxt  = step_dir;
               cons_nxt = '0;
            end else if (!hold_ok) begin
               serr_nxt = 1'b1;
               if (err_cnt != '1) err_nxt = err_cnt + 1'b1;
               if (cons == CONS_W'(ERR_LIMIT - 1)) begin
                  state_nxt = ACQ;
                  cons_nxt  = '0;
               end else begin
                  cons_nxt = cons + 1'b1;
               end
            end
         end
         default: state_nxt = ACQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ACQ;
         prev_gray        <= '0;
         cons             <= '0;
         err_cnt          <= '0;
         bus.out_valid    <= 1'b0;
         bus.out_bin      <= '0;
         bus.out_dir      <= 1'b0;
         bus.out_first    <= 1'b0;
         bus.out_step_err <= 1'b0;
      end else if (accept) begin
         state            <= state_nxt;
         prev_gray        <= bus.in_gray;
         cons             <= cons_nxt;
         err_cnt          <= err_nxt;
         bus.out_valid    <= 1'b1;
         bus.out_bin      <= cur_bin;
         bus.out_dir      <= dir_nxt;
         bus.out_first    <= first_nxt;
         bus.out_step_err <= serr_nxt;
      end else if (bus.out_valid && bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_gray_stream_decoder.sv
// Directed self-checking bench for gray_stream_decoder (WIDTH=8, ERR_LIMIT=3).
module tb_gray_stream_decoder;
   logic        clk = 1'b0;
   logic        rst;
   logic        locked;
   logic [15:0] err_cnt;
   int          passed = 0;
   int          total  = 0;

   gray_stream_decoder_if #(.WIDTH(8)) bus ();

   gray_stream_decoder #(.WIDTH(8), .ERR_LIMIT(3), .CNT_W(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .locked  (locked),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; bus.in_valid = 1'b0; bus.in_gray = '0; bus.out_ready = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One-cycle offer of a word; outputs sampled 1 time unit after the edge.
   task automatic send(input logic [7:0] g);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_gray = g;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); else passed++;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL reset_locked got %0b want 0", locked); else passed++;
      total++; if (err_cnt !== 16'd0) $display("FAIL reset_err_cnt got %0d want 0", err_cnt); else passed++;
      total++; if ({bus.out_bin, bus.out_dir, bus.out_first, bus.out_step_err} !== 11'd0)
         $display("FAIL reset_out_fields got %h want 0", {bus.out_bin, bus.out_dir, bus.out_first, bus.out_step_err}); else passed++;
   endtask

   task automatic test_stream();
      logic [7:0] codes [10];
      codes = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C, 8'h0D};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         send(codes[i]);
         total++; if (bus.out_valid !== 1'b1 || bus.out_bin !== 8'(i))
            $display("FAIL stream_bin[%0d] got v=%0b %h want v=1 %h", i, bus.out_valid, bus.out_bin, 8'(i)); else passed++;
         total++; if (bus.out_first !== (i == 0) || bus.out_dir !== (i != 0) || bus.out_step_err !== 1'b0)
            $display("FAIL stream_flags[%0d] got first=%0b dir=%0b err=%0b", i, bus.out_first, bus.out_dir, bus.out_step_err); else passed++;
         total++; if (locked !== 1'b1) $display("FAIL stream_locked[%0d] got %0b want 1", i, locked); else passed++;
      end
      total++; if (err_cnt !== 16'd0) $display("FAIL stream_err_cnt got %0d want 0", err_cnt); else passed++;
   endtask

   task automatic test_wrap();
      do_reset();
      send(8'h80);
      total++; if (bus.out_bin !== 8'hFF || bus.out_first !== 1'b1) $display("FAIL wrap_up_ref got %h first=%0b want ff 1", bus.out_bin, bus.out_first); else passed++;
      send(8'h00);
      total++; if (bus.out_bin !== 8'h00 || bus.out_dir !== 1'b1 || bus.out_step_err !== 1'b0)
         $display("FAIL wrap_up got %h dir=%0b err=%0b want 00 1 0", bus.out_bin, bus.out_dir, bus.out_step_err); else passed++;
      do_reset();
      send(8'h00);
      send(8'h80);
      total++; if (bus.out_bin !== 8'hFF || bus.out_dir !== 1'b0 || bus.out_step_err !== 1'b0 || bus.out_first !== 1'b0)
         $display("FAIL wrap_down got %h dir=%0b err=%0b first=%0b want ff 0 0 0", bus.out_bin, bus.out_dir, bus.out_step_err, bus.out_first); else passed++;
      total++; if (err_cnt !== 16'd0) $display("FAIL wrap_err_cnt got %0d want 0", err_cnt); else passed++;
   endtask

   task automatic test_err_relock();
      logic [7:0] bad [3];
      bad = '{8'h0F, 8'h3C, 8'hF0};
      do_reset();
      send(8'h01);
      for (int i = 0; i < 3; i++) begin
         send(bad[i]);
         total++; if (bus.out_step_err !== 1'b1 || bus.out_dir !== 1'b0)
            $display("FAIL err_flag[%0d] got err=%0b dir=%0b want 1 0", i, bus.out_step_err, bus.out_dir); else passed++;
         total++; if (err_cnt !== 16'(i + 1)) $display("FAIL err_cnt[%0d] got %0d want %0d", i, err_cnt, i + 1); else passed++;
         total++; if (locked !== (i < 2)) $display("FAIL err_locked[%0d] got %0b want %0b", i, locked, i < 2); else passed++;
      end
      send(8'h07);
      total++; if (bus.out_first !== 1'b1 || bus.out_bin !== 8'h05 || bus.out_step_err !== 1'b0)
         $display("FAIL relock_word got first=%0b bin=%h err=%0b want 1 05 0", bus.out_first, bus.out_bin, bus.out_step_err); else passed++;
      total++; if (locked !== 1'b1 || err_cnt !== 16'd3) $display("FAIL relock_state got locked=%0b err_cnt=%0d want 1 3", locked, err_cnt); else passed++;
   endtask

   task automatic test_backpressure();
      do_reset();
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_gray = 8'h00;
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b1 || bus.out_bin !== 8'h00) $display("FAIL bp_first got v=%0b %h want 1 00", bus.out_valid, bus.out_bin); else passed++;
      @(negedge clk);
      bus.in_gray = 8'h01;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %0b want 0", i, bus.in_ready); else passed++;
         total++; if (bus.out_valid !== 1'b1 || bus.out_bin !== 8'h00 || bus.out_first !== 1'b1)
            $display("FAIL bp_stable[%0d] got v=%0b %h first=%0b want 1 00 1", i, bus.out_valid, bus.out_bin, bus.out_first); else passed++;
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b1 || bus.out_bin !== 8'h01 || bus.out_dir !== 1'b1 || bus.out_first !== 1'b0)
         $display("FAIL bp_release got v=%0b %h dir=%0b first=%0b want 1 01 1 0", bus.out_valid, bus.out_bin, bus.out_dir, bus.out_first); else passed++;
      @(negedge clk);
      bus.in_gray = 8'h03;
      @(posedge clk); #1;
      total++; if (bus.out_bin !== 8'h02 || bus.out_step_err !== 1'b0) $display("FAIL bp_next got %h err=%0b want 02 0", bus.out_bin, bus.out_step_err); else passed++;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drain got v=%0b want 0", bus.out_valid); else passed++;
   endtask

   task automatic test_repeat();
      do_reset();
      send(8'h03);
      send(8'h03);
`ifdef GRAY_DEC_REPEAT_OK_EN
      total++; if (bus.out_step_err !== 1'b0 || bus.out_dir !== 1'b0 || bus.out_bin !== 8'h02)
         $display("FAIL repeat_hold got err=%0b dir=%0b bin=%h want 0 0 02", bus.out_step_err, bus.out_dir, bus.out_bin); else passed++;
      total++; if (err_cnt !== 16'd0) $display("FAIL repeat_err_cnt got %0d want 0", err_cnt); else passed++;
`else
      total++; if (bus.out_step_err !== 1'b1 || bus.out_dir !== 1'b0 || bus.out_bin !== 8'h02)
         $display("FAIL repeat_err got err=%0b dir=%0b bin=%h want 1 0 02", bus.out_step_err, bus.out_dir, bus.out_bin); else passed++;
      total++; if (err_cnt !== 16'd1) $display("FAIL repeat_err_cnt got %0d want 1", err_cnt); else passed++;
`endif
   endtask

   task automatic test_reset_midstream();
      do_reset();
      send(8'h01);
      send(8'h0F);
      total++; if (err_cnt !== 16'd1) $display("FAIL mid_pre_err_cnt got %0d want 1", err_cnt); else passed++;
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_gray = 8'h03;
      @(posedge clk); #1;
      total++; if (bus.in_ready !== 1'b0 || bus.out_bin !== 8'h0A) $display("FAIL mid_stall got rdy=%0b bin=%h want 0 0a", bus.in_ready, bus.out_bin); else passed++;
      @(negedge clk);
      rst = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0 || err_cnt !== 16'd0 || locked !== 1'b0)
         $display("FAIL mid_reset got v=%0b err_cnt=%0d locked=%0b want 0 0 0", bus.out_valid, err_cnt, locked); else passed++;
      @(negedge clk);
      rst = 1'b0; bus.in_valid = 1'b0;
      send(8'h0F);
      total++; if (bus.out_first !== 1'b1 || bus.out_bin !== 8'h0A || bus.out_step_err !== 1'b0)
         $display("FAIL mid_ref got first=%0b bin=%h err=%0b want 1 0a 0", bus.out_first, bus.out_bin, bus.out_step_err); else passed++;
   endtask

   initial begin
      rst = 1'b1; bus.in_valid = 1'b0; bus.in_gray = '0; bus.out_ready = 1'b1;
      test_reset();
      test_stream();
      test_wrap();
      test_err_relock();
      test_backpressure();
      test_repeat();
      test_reset_midstream();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
